// File: rtl/param_frame_pkg.sv
// Shared types and constants for the parameter frame serializer.
// The HEADER state is present only when PARAM_FRAME_HEADER_EN is defined.
package param_frame_pkg;

  localparam logic [3:0] HDR_NIBBLE = 4'hA;
  localparam int         CHIPID_W   = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    NEXT_CHIP,
    DONE
`ifdef PARAM_FRAME_HEADER_EN
    , HEADER
`endif
  } state_e;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/param_word_shifter.sv
// Holds one frame vector left-aligned in REG_W bits (zero padded below) and
// shifts it left one word per enable; the top word is always presented.
module param_word_shifter #(
  parameter int SC_BITS    = 592,
  parameter int SCOPE_BITS = 64,
  parameter int WORD_W     = 16,
  parameter int REG_W      = 592
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  sel_sc,
  input  logic                  shift_en,
  input  logic [SC_BITS-1:0]    sc_vec,
  input  logic [SCOPE_BITS-1:0] scope_vec,
  output logic [WORD_W-1:0]     top_word
);

  localparam int SC_SHIFT    = REG_W - SC_BITS;
  localparam int SCOPE_SHIFT = REG_W - SCOPE_BITS;

  logic [REG_W-1:0] sreg_q, sreg_d;

  always_comb begin
    sreg_d = sreg_q;
    if (load) begin
      sreg_d = sel_sc ? (REG_W'(sc_vec) << SC_SHIFT) : (REG_W'(scope_vec) << SCOPE_SHIFT);
    end else if (shift_en) begin
      sreg_d = sreg_q << WORD_W;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) sreg_q <= '0;
    else     sreg_q <= sreg_d;
  end

  assign top_word = sreg_q[REG_W-1 -: WORD_W];

endmodule

// File: rtl/param_frame_serializer.sv
// Splits an SC or read-scope vector into FIFO words, once per daisy-chained chip.
// Optional per-chip header word enabled by defining PARAM_FRAME_HEADER_EN.
module param_frame_serializer
  import param_frame_pkg::*;
#(
  parameter int SC_BITS    = 592,
  parameter int SCOPE_BITS = 64,
  parameter int WORD_W     = 16,
  parameter int ASIC_NUM   = 1,
  parameter int CHIPID_LSB = 530
) (
  input  logic                  Clk,
  input  logic                  reset,
  input  logic                  ParameterLoadStart,
  input  logic                  SlowControlOrReadScopeSelect,
  input  logic [SC_BITS-1:0]    SlowControlParameter,
  input  logic [SCOPE_BITS-1:0] ReadScopeParameter,
  input  logic [7:0]            ChipIdBase,
  input  logic                  ExternalFifoFull,
  output logic                  ExternalFifoWriteEn,
  output logic [WORD_W-1:0]     ExternalFifoData,
  output logic                  Busy,
  output logic                  ParameterDone
);

  localparam int SC_WORDS    = ceil_div(SC_BITS, WORD_W);
  localparam int SCOPE_WORDS = ceil_div(SCOPE_BITS, WORD_W);
  localparam int MAX_WORDS   = (SC_WORDS > SCOPE_WORDS) ? SC_WORDS : SCOPE_WORDS;
  localparam int REG_W       = MAX_WORDS * WORD_W;
  localparam int WCNT_W      = $clog2(MAX_WORDS + 1);

  state_e              state_q, state_d;
  logic                mode_q, mode_d;
  logic [3:0]          chip_q, chip_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic                load, shift_en;
  logic [WORD_W-1:0]   top_word;
  logic [SC_BITS-1:0]  sc_patched;

  always_comb begin
    sc_patched = SlowControlParameter;
    sc_patched[CHIPID_LSB +: CHIPID_W] = ChipIdBase + CHIPID_W'(chip_q);
  end

  param_word_shifter #(
    .SC_BITS   (SC_BITS),
    .SCOPE_BITS(SCOPE_BITS),
    .WORD_W    (WORD_W),
    .REG_W     (REG_W)
  ) u_shifter (
    .clk      (Clk),
    .rst      (reset),
    .load     (load),
    .sel_sc   (mode_q),
    .shift_en (shift_en),
    .sc_vec   (sc_patched),
    .scope_vec(ReadScopeParameter),
    .top_word (top_word)
  );

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d             = state_q;
    mode_d              = mode_q;
    chip_d              = chip_q;
    wcnt_d              = wcnt_q;
    load                = 1'b0;
    shift_en            = 1'b0;
    ExternalFifoWriteEn = 1'b0;
    ExternalFifoData    = '0;
    case (state_q)
      IDLE: begin
        if (ParameterLoadStart) begin
          mode_d  = SlowControlOrReadScopeSelect;
          chip_d  = 4'(ASIC_NUM - 1);
          state_d = LOAD;
        end
      end
      LOAD: begin
        load   = 1'b1;
        wcnt_d = mode_q ? WCNT_W'(SC_WORDS - 1) : WCNT_W'(SCOPE_WORDS - 1);
`ifdef PARAM_FRAME_HEADER_EN
        state_d = HEADER;
`else
        state_d = SHIFT;
`endif
      end
`ifdef PARAM_FRAME_HEADER_EN
      HEADER: begin
        ExternalFifoData    = WORD_W'({HDR_NIBBLE, mode_q, chip_q}) << (WORD_W - 9);
        ExternalFifoWriteEn = !ExternalFifoFull;
        if (!ExternalFifoFull) state_d = SHIFT;
      end
`endif
      SHIFT: begin
        ExternalFifoData    = top_word;
        ExternalFifoWriteEn = !ExternalFifoFull;
        if (!ExternalFifoFull) begin
          shift_en = 1'b1;
          if (wcnt_q == '0) state_d = NEXT_CHIP;
          else              wcnt_d  = wcnt_q - WCNT_W'(1);
        end
      end
      NEXT_CHIP: begin
        // Highest chip index goes out first: it sits farthest down the chain.
        if (chip_q == 4'd0) begin
          state_d = DONE;
        end else begin
          chip_d  = chip_q - 4'd1;
          state_d = LOAD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      chip_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      chip_q  <= chip_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign Busy          = (state_q != IDLE);
  assign ParameterDone = (state_q == DONE);

endmodule
